// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues 16-bit word reads to instruction memory
// (one-cycle read latency) and queues {pc, instr} pairs in a small FIFO that
// decode drains. Redirects flush everything; halt stops new issues but lets
// the in-flight read land and the FIFO drain.
module fetch_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] imem_raddr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [15:0]    pc_q, pc_d;
    logic [15:0]    ipc_q, ipc_d;
    logic           inflight_q, inflight_d;
    logic           halted_q, halted_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    buf_q [DEPTH];

    logic           pop;
    logic           push;
    logic           issue;
    logic [CW:0]    used;

    assign imem_raddr = pc_q[15:1];
    assign out_valid  = (count_q != '0);
    assign out_pc     = buf_q[rd_ptr_q][31:16];
    assign out_instr  = buf_q[rd_ptr_q][15:0];

    // Issue/push/pop decisions and next state; redirect overrides everything
    // except that a coincident halt still becomes sticky.
    always_comb begin
        pop   = out_valid & out_ready;
        // Credit: entries held plus the one in flight, minus the one leaving.
        used  = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
        issue = !halted_q && !halt && !redirect && (used < DEPTH_W);
        push  = inflight_q & !redirect;

        pc_d       = pc_q;
        ipc_d      = ipc_q;
        inflight_d = 1'b0;
        halted_d   = halted_q | halt;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect) begin
            pc_d     = redirect_pc & 16'hFFFE;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            wr_ptr_d   = wr_ptr_q + PW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                pc_d  = pc_q + 16'd2;
                ipc_d = pc_q;
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= {ipc_q, imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the fetch stream.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] imem_raddr;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_raddr  (imem_raddr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: word[i] = 0x8000 + i, one-cycle read latency.
    always @(posedge clk) imem_rdata <= 16'h8000 + {1'b0, imem_raddr};

    // Reference model: the expected delivery queue plus fetch-side state.
    logic [31:0] mq[$];
    logic [15:0] m_pc;
    logic [15:0] m_ipc;
    bit          m_infl;
    bit          m_halted;

    function automatic logic [15:0] word_at(input logic [15:0] byte_addr);
        return 16'h8000 + {1'b0, byte_addr[15:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = '0;
        m_ipc = '0;
        m_infl = 0;
        m_halted = 0;
    endtask

    task automatic model_step(input bit rdy, input bit rd, input logic [15:0] rpc, input bit hl);
        int  n;
        bit  pop;
        bit  iss;
        n   = mq.size();
        pop = (n != 0) && rdy;
        iss = !m_halted && !hl && !rd && ((n + int'(m_infl) - int'(pop)) < int'(DEPTH));
        if (rd) begin
            mq.delete();
            m_infl = 0;
            m_pc   = {rpc[15:1], 1'b0};
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back({m_ipc, word_at(m_ipc)});
            if (iss) begin
                m_ipc  = m_pc;
                m_pc   = m_pc + 16'd2;
                m_infl = 1;
            end else begin
                m_infl = 0;
            end
        end
        if (hl) m_halted = 1;
    endtask

    task automatic compare();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("imem_raddr", {17'b0, imem_raddr}, {17'b0, m_pc[15:1]});
        if (mq.size() != 0) begin
            chk("out_pc", {16'b0, out_pc}, {16'b0, mq[0][31:16]});
            chk("out_instr", {16'b0, out_instr}, {16'b0, mq[0][15:0]});
        end
    endtask

    // One clock: drive inputs after a falling edge, step the model on the
    // rising edge, compare on the next falling edge.
    task automatic cycle(input bit rdy, input bit rd, input logic [15:0] rpc, input bit hl);
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        @(posedge clk);
        model_step(rdy, rd, rpc, hl);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk(name, {16'b0, act}, {16'b0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, streaming with out_ready=1.
        do_reset();
        lit("rst_valid", {15'b0, out_valid}, 16'h0);
        cycle(1, 0, '0, 0);
        lit("s_e1_valid", {15'b0, out_valid}, 16'h0);
        cycle(1, 0, '0, 0);
        lit("s_e2_valid", {15'b0, out_valid}, 16'h1);
        lit("s_e2_pc", out_pc, 16'h0000);
        lit("s_e2_instr", out_instr, 16'h8000);
        cycle(1, 0, '0, 0);
        lit("s_e3_pc", out_pc, 16'h0002);
        lit("s_e3_instr", out_instr, 16'h8001);
        cycle(1, 0, '0, 0);
        lit("s_e4_pc", out_pc, 16'h0004);
        lit("s_e4_instr", out_instr, 16'h8002);

        // Backpressure until full, then drain with no bubble.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0);
        lit("full_head", out_pc, 16'h0000);
        lit("full_raddr", {1'b0, imem_raddr}, 16'h0004);
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 0, '0, 0);
            lit("drain_valid", {15'b0, out_valid}, 16'h1);
            lit("drain_pc", out_pc, 16'(2 * i));
        end

        // Redirect with 3 queued entries and one in flight.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 0);
        cycle(1, 1, 16'h0041, 0);
        lit("redir_e1_valid", {15'b0, out_valid}, 16'h0);
        cycle(1, 0, '0, 0);
        lit("redir_e2_valid", {15'b0, out_valid}, 16'h0);
        cycle(1, 0, '0, 0);
        lit("redir_first_pc", out_pc, 16'h0040);
        lit("redir_first_instr", out_instr, 16'h8020);
        cycle(1, 0, '0, 0);
        lit("redir_second_pc", out_pc, 16'h0042);

        // Wrap through 0xFFFE -> 0x0000.
        cycle(1, 1, 16'hFFFC, 0);
        cycle(1, 0, '0, 0);
        cycle(1, 0, '0, 0);
        lit("wrap_pc0", out_pc, 16'hFFFC);
        lit("wrap_instr0", out_instr, 16'hFFFE);
        cycle(1, 0, '0, 0);
        lit("wrap_pc1", out_pc, 16'hFFFE);
        lit("wrap_instr1", out_instr, 16'hFFFF);
        cycle(1, 0, '0, 0);
        lit("wrap_pc2", out_pc, 16'h0000);
        lit("wrap_instr2", out_instr, 16'h8000);

        // Half-cycle asynchronous reset mid-stream.
        cycle(1, 0, '0, 0);
        #1 rst_n = 1'b0;
        #1 model_reset();
        lit("async_valid", {15'b0, out_valid}, 16'h0);
        compare();
        #2 rst_n = 1'b1;
        cycle(1, 0, '0, 0);
        lit("arst_e1_valid", {15'b0, out_valid}, 16'h0);
        cycle(1, 0, '0, 0);
        lit("arst_e2_pc", out_pc, 16'h0000);
        cycle(1, 0, '0, 0);
        lit("arst_e3_pc", out_pc, 16'h0002);

        // Random traffic; occasional reset once halted so fetching resumes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            bit rd;
            bit hl;
            rdy = ((i / 64) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            hl  = ($urandom_range(0, 249) == 0);
            if (m_halted && $urandom_range(0, 15) == 0) begin
                do_reset();
            end else begin
                cycle(rdy, rd, 16'($urandom), hl);
            end
        end

        // Halt at pc 0x0010 with 0x000E in flight.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, '0, 0);
        lit("halt_raddr", {1'b0, imem_raddr}, 16'h0008);
        cycle(1, 0, '0, 1);
        lit("halt_last_pc", out_pc, 16'h000E);
        lit("halt_last_instr", out_instr, 16'h8007);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, '0, 0);
            lit("halt_drained", {15'b0, out_valid}, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction-buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_raddr, output, 15 bits: word address to instruction memory, equal to pc[15:1].
REQ-005 SHALL have port imem_rdata, input, 16 bits: instruction word, valid one cycle after the address is presented.
REQ-006 SHALL have port redirect, input, 1 bit: flush request from execute (taken jump or mispredict).
REQ-007 SHALL have port redirect_pc, input, 16 bits: new fetch address, sampled when redirect=1.
REQ-008 SHALL have port halt, input, 1 bit: stop-fetch request.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle (decode stall = 0).
REQ-011 SHALL have port out_instr, output, 16 bits: instruction at buffer head.
REQ-012 SHALL have port out_pc, output, 16 bits: byte address of out_instr.

Function
REQ-013 SHALL hold a 16-bit pc, a DEPTH-entry FIFO of {pc, instr}, an occupancy count, a 1-bit in-flight flag with its captured pc, and a sticky halted flag.
REQ-014 SHALL pop the head on a rising edge where out_valid & out_ready; out_valid SHALL equal (count != 0), and out_instr/out_pc SHALL be the head entry, not qualified by anything else.
REQ-015 SHALL issue a fetch on an edge when !halted & !redirect & (count + inflight - pop) < DEPTH; an issue sets inflight=1, captures pc, and advances pc by 2.
REQ-016 SHALL wrap pc from 0xFFFE to 0x0000 without error.
REQ-017 SHALL push {captured pc, imem_rdata} into the FIFO on the edge after an issue, unless that fetch was squashed; inflight clears on that edge unless a new issue occurs.
REQ-018 SHALL support a simultaneous push and pop in the same cycle with count unchanged, including at count = DEPTH-1 and count = DEPTH.
REQ-019 SHALL never push when full; the credit rule of REQ-015 guarantees this, and overflow is a design error.
REQ-020 SHALL, on redirect=1, take precedence over issue, push, pop, and halt: pc <= {redirect_pc[15:1], 1'b0}; count <= 0; the in-flight fetch is squashed (never pushed); no issue that cycle.
REQ-021 SHALL assert out_valid again no earlier than 2 edges after the redirect edge (one issue edge, one push edge).
REQ-022 SHALL, on halt=1, set halted, which is sticky until reset; no further issues occur; an in-flight fetch still completes its push; the FIFO continues to drain via out_ready.
REQ-023 SHALL make halt=1 and a redirect in the same cycle apply the redirect to pc and the FIFO, and also set halted.
REQ-024 SHALL drive imem_raddr combinationally from pc at all times; reads made without an issue are don't-care.
REQ-025 SHALL have an issue-to-out_valid latency of 2 rising edges when the FIFO is empty and out_ready=1; sustained throughput SHALL be 1 instruction/cycle.

Reset
REQ-026 SHALL, while rst_n=0, immediately force pc=0x0000, count=0, inflight=0, halted=0, out_valid=0, and FIFO pointers to 0; FIFO data need not be reset.
REQ-027 SHALL discard any fetch in flight when reset asserts mid-operation; the first issue after release SHALL be pc 0x0000 on the first rising edge with rst_n=1.

Verification
REQ-028 SHALL cover: reset release with out_ready=1 and memory returning word[i]=0x8000+i -> out_valid rises after edge 2; out_pc sequence 0x0000, 0x0002, 0x0004 on consecutive cycles with matching instrs.
REQ-029 SHALL cover: out_ready=0 for 10 cycles -> count saturates at DEPTH=4 with heads 0x0000..0x0006 and no issue while full; out_ready=1 -> 4 pops in order, then a stream from 0x0008 with no bubble.
REQ-030 SHALL cover: redirect=1 with redirect_pc=0x0041 while FIFO holds 3 entries and a fetch is in flight -> out_valid=0 on the next cycle; first out_pc=0x0040 after 2 edges; none of the squashed pcs ever appear.
REQ-031 SHALL cover: halt pulse at pc=0x0010 with an in-flight fetch of 0x000E -> 0x000E is delivered, nothing from 0x0010 onward, and out_valid stays 0 after the drain.
REQ-032 SHALL cover: redirect_pc=0xFFFC -> out_pc sequence 0xFFFC, 0xFFFE, 0x0000.
REQ-033 SHALL cover: rst_n pulled low for one half-cycle mid-stream -> out_valid=0 asynchronously; after release the stream restarts at 0x0000.
